// File: rtl/fb_plot_sink_if.sv
// Plot, clear and readback signals between a drawing engine (master) and the
// framebuffer sink (slave).
interface fb_plot_sink_if #(
  parameter int unsigned CBITS = 3
);
  logic [7:0]       VGA_X;
  logic [6:0]       VGA_Y;
  logic [CBITS-1:0] VGA_COLOUR;
  logic             VGA_PLOT;
  logic             clear_start;
  logic [CBITS-1:0] clear_colour;
  logic             busy;
  logic             rd_req;
  logic [7:0]       rd_x;
  logic [6:0]       rd_y;
  logic             rd_valid;
  logic [CBITS-1:0] rd_colour;
  logic [14:0]      plot_count;
  logic [7:0]       oob_count;

  modport master (
    output VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, clear_start, clear_colour,
    output rd_req, rd_x, rd_y,
    input  busy, rd_valid, rd_colour, plot_count, oob_count
  );

  modport slave (
    input  VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT, clear_start, clear_colour,
    input  rd_req, rd_x, rd_y,
    output busy, rd_valid, rd_colour, plot_count, oob_count
  );
endinterface

// File: rtl/fb_plot_sink.sv
// 160x120 pixel sink: accepts plot strobes into a frame memory, with a
// full-screen clear sweep, 1-cycle readback and plot/out-of-range counters.
module fb_plot_sink #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120,
  parameter int unsigned CBITS  = 3
) (
  input logic            CLOCK_50,
  input logic            reset,
  fb_plot_sink_if.slave  bus
);

  localparam int unsigned Depth    = WIDTH * HEIGHT;
  localparam logic [7:0]  XLim     = 8'(WIDTH);
  localparam logic [6:0]  YLim     = 7'(HEIGHT);
  localparam logic [14:0] LastAddr = 15'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // y*160 + x as two shifts and adds
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  endfunction

  state_e           state_d, state_q;
  logic [14:0]      clr_addr_d, clr_addr_q;
  logic [CBITS-1:0] clr_colour_d, clr_colour_q;
  logic [14:0]      plot_count_d, plot_count_q;
  logic [7:0]       oob_count_d, oob_count_q;
  logic             rd_valid_d, rd_valid_q;
  logic             rd_hit_d, rd_hit_q;

  logic             mem_we;
  logic [14:0]      mem_waddr;
  logic [CBITS-1:0] mem_wdata;
  logic             mem_re;
  logic [14:0]      mem_raddr;
  logic [CBITS-1:0] mem_rdata_q;
  logic [CBITS-1:0] mem [Depth];

  logic plot_in_range;
  logic rd_in_range;

  assign plot_in_range = (bus.VGA_X < XLim) && (bus.VGA_Y < YLim);
  assign rd_in_range   = (bus.rd_x < XLim) && (bus.rd_y < YLim);

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_colour_d = clr_colour_q;
    plot_count_d = plot_count_q;
    oob_count_d  = oob_count_q;
    rd_valid_d   = 1'b0;
    rd_hit_d     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = pix_addr(bus.VGA_X, bus.VGA_Y);
    mem_wdata    = bus.VGA_COLOUR;
    mem_re       = 1'b0;
    mem_raddr    = pix_addr(bus.rd_x, bus.rd_y);

    unique case (state_q)
      StIdle: begin
        if (bus.VGA_PLOT) begin
          if (plot_in_range) begin
            mem_we = 1'b1;
            if (plot_count_q != 15'h7fff) plot_count_d = plot_count_q + 15'd1;
          end else if (oob_count_q != 8'hff) begin
            oob_count_d = oob_count_q + 8'd1;
          end
        end
        if (bus.rd_req) begin
          rd_valid_d = 1'b1;
          rd_hit_d   = rd_in_range;
          mem_re     = rd_in_range;
        end
        // A plot in the same cycle is still written; the sweep overwrites it.
        if (bus.clear_start) begin
          clr_colour_d = bus.clear_colour;
          clr_addr_d   = '0;
          plot_count_d = '0;
          state_d      = StClear;
        end
      end
      StClear: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = clr_colour_q;
        clr_addr_d = clr_addr_q + 15'd1;
        if (clr_addr_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Nothing sampled alongside reset may touch the memory.
    if (reset) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= StIdle;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
      plot_count_q <= '0;
      oob_count_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_colour_q <= clr_colour_d;
      plot_count_q <= plot_count_d;
      oob_count_q  <= oob_count_d;
      rd_valid_q   <= rd_valid_d;
      rd_hit_q     <= rd_hit_d;
    end
  end

  // Frame memory is not reset; non-blocking read gives read-before-write.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata_q <= mem[mem_raddr];
  end

  assign bus.busy       = (state_q == StClear);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_colour  = rd_hit_q ? mem_rdata_q : '0;
  assign bus.plot_count = plot_count_q;
  assign bus.oob_count  = oob_count_q;

endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed bench for fb_plot_sink: inputs driven and outputs sampled on the
// falling clock edge.
module tb_fb_plot_sink;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_plot_sink_if bus ();

  fb_plot_sink dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic idle_bus();
    bus.VGA_X        = '0;
    bus.VGA_Y        = '0;
    bus.VGA_COLOUR   = '0;
    bus.VGA_PLOT     = 1'b0;
    bus.clear_start  = 1'b0;
    bus.clear_colour = '0;
    bus.rd_req       = 1'b0;
    bus.rd_x         = '0;
    bus.rd_y         = '0;
  endtask

  task automatic plot_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    bus.VGA_X      = x;
    bus.VGA_Y      = y;
    bus.VGA_COLOUR = c;
    bus.VGA_PLOT   = 1'b1;
    @(negedge clk);
    bus.VGA_PLOT   = 1'b0;
  endtask

  task automatic read_px(input logic [7:0] x, input logic [6:0] y,
                         output logic v, output logic [2:0] c);
    bus.rd_req = 1'b1;
    bus.rd_x   = x;
    bus.rd_y   = y;
    @(negedge clk);
    bus.rd_req = 1'b0;
    v = bus.rd_valid;
    c = bus.rd_colour;
  endtask

  // Returns the number of cycles busy was seen high; with noise set, plots and
  // reads are held throughout the sweep and any rd_valid is tallied.
  task automatic run_clear(input logic [2:0] colour, input bit noise,
                           output int busy_cycles, output int rd_bad);
    bus.clear_start  = 1'b1;
    bus.clear_colour = colour;
    @(negedge clk);
    bus.clear_start  = 1'b0;
    if (noise) begin
      bus.VGA_X = 8'd20; bus.VGA_Y = 7'd20; bus.VGA_COLOUR = 3'b111; bus.VGA_PLOT = 1'b1;
      bus.rd_x  = 8'd20; bus.rd_y  = 7'd20; bus.rd_req = 1'b1;
    end
    busy_cycles = 0;
    rd_bad      = 0;
    while (bus.busy === 1'b1 && busy_cycles < 20000) begin
      busy_cycles++;
      if (bus.rd_valid !== 1'b0) rd_bad++;
      @(negedge clk);
    end
    if (bus.rd_valid !== 1'b0) rd_bad++;
    bus.VGA_PLOT = 1'b0;
    bus.rd_req   = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    bus.VGA_X = 8'd5; bus.VGA_Y = 7'd5; bus.VGA_COLOUR = 3'b110; bus.VGA_PLOT = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.VGA_PLOT = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid);
    end
    vectors++;
    if (bus.rd_colour !== 3'b000) begin
      miscompares++; $display("FAIL reset_rd_colour: got %b expected 000", bus.rd_colour);
    end
    vectors++;
    if (bus.plot_count !== 15'd0) begin
      miscompares++; $display("FAIL reset_plot_count: got %0d expected 0", bus.plot_count);
    end
    vectors++;
    if (bus.oob_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_oob_count: got %0d expected 0", bus.oob_count);
    end
  endtask

  task automatic test_clear_and_plot();
    int n, bad;
    logic v;
    logic [2:0] c;
    run_clear(3'b000, 1'b0, n, bad);
    vectors++;
    if (n != 19200) begin
      miscompares++; $display("FAIL clear0_busy_len: got %0d expected 19200", n);
    end
    plot_px(8'd0, 7'd0, 3'b010);
    vectors++;
    if (bus.plot_count !== 15'd1) begin
      miscompares++; $display("FAIL plot_count_first: got %0d expected 1", bus.plot_count);
    end
    plot_px(8'd159, 7'd119, 3'b101);
    plot_px(8'd80, 7'd60, 3'b111);
    vectors++;
    if (bus.plot_count !== 15'd3) begin
      miscompares++; $display("FAIL plot_count_3: got %0d expected 3", bus.plot_count);
    end
    read_px(8'd0, 7'd0, v, c);
    vectors++;
    if ({v, c} !== 4'b1_010) begin
      miscompares++; $display("FAIL read_0_0: got v=%b c=%b expected v=1 c=010", v, c);
    end
    read_px(8'd159, 7'd119, v, c);
    vectors++;
    if ({v, c} !== 4'b1_101) begin
      miscompares++; $display("FAIL read_159_119: got v=%b c=%b expected v=1 c=101", v, c);
    end
    read_px(8'd80, 7'd60, v, c);
    vectors++;
    if ({v, c} !== 4'b1_111) begin
      miscompares++; $display("FAIL read_80_60: got v=%b c=%b expected v=1 c=111", v, c);
    end
    @(negedge clk);
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL rd_valid_drop: got %b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_oob();
    logic v;
    logic [2:0] c;
    plot_px(8'd160, 7'd0, 3'b111);
    plot_px(8'd0, 7'd120, 3'b111);
    plot_px(8'd255, 7'd127, 3'b111);
    vectors++;
    if (bus.oob_count !== 8'd3) begin
      miscompares++; $display("FAIL oob_count: got %0d expected 3", bus.oob_count);
    end
    vectors++;
    if (bus.plot_count !== 15'd3) begin
      miscompares++; $display("FAIL oob_plot_count: got %0d expected 3", bus.plot_count);
    end
    read_px(8'd160, 7'd0, v, c);
    vectors++;
    if ({v, c} !== 4'b1_000) begin
      miscompares++; $display("FAIL read_oob: got v=%b c=%b expected v=1 c=000", v, c);
    end
    read_px(8'd0, 7'd0, v, c);
    vectors++;
    if ({v, c} !== 4'b1_010) begin
      miscompares++; $display("FAIL oob_no_write: got v=%b c=%b expected v=1 c=010", v, c);
    end
  endtask

  task automatic test_reset_with_plot();
    logic v;
    logic [2:0] c;
    rst = 1'b1;
    bus.VGA_X = 8'd5; bus.VGA_Y = 7'd5; bus.VGA_COLOUR = 3'b110; bus.VGA_PLOT = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.VGA_PLOT = 1'b0;
    vectors++;
    if ({bus.plot_count, bus.oob_count} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got plot=%0d oob=%0d expected 0 0", bus.plot_count,
               bus.oob_count);
    end
    read_px(8'd5, 7'd5, v, c);
    vectors++;
    if ({v, c} !== 4'b1_000) begin
      miscompares++; $display("FAIL reset_no_write: got v=%b c=%b expected v=1 c=000", v, c);
    end
  endtask

  task automatic test_clear_sweep();
    int n, bad;
    logic v;
    logic [2:0] c;
    run_clear(3'b100, 1'b1, n, bad);
    vectors++;
    if (n != 19200) begin
      miscompares++; $display("FAIL clear4_busy_len: got %0d expected 19200", n);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL clear_rd_ignored: got %0d valid cycles expected 0", bad);
    end
    vectors++;
    if (bus.plot_count !== 15'd0) begin
      miscompares++; $display("FAIL clear_plot_ignored: got %0d expected 0", bus.plot_count);
    end
    read_px(8'd0, 7'd0, v, c);
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL clr_read_0_0: got v=%b c=%b expected v=1 c=100", v, c);
    end
    read_px(8'd79, 7'd59, v, c);
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL clr_read_79_59: got v=%b c=%b expected v=1 c=100", v, c);
    end
    read_px(8'd159, 7'd119, v, c);
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL clr_read_159_119: got v=%b c=%b expected v=1 c=100", v, c);
    end
    read_px(8'd20, 7'd20, v, c);
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL clr_read_20_20: got v=%b c=%b expected v=1 c=100", v, c);
    end
  endtask

  task automatic test_read_before_write();
    logic v;
    logic [2:0] c;
    bus.VGA_X = 8'd10; bus.VGA_Y = 7'd10; bus.VGA_COLOUR = 3'b011; bus.VGA_PLOT = 1'b1;
    read_px(8'd10, 7'd10, v, c);
    bus.VGA_PLOT = 1'b0;
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL rbw_old: got v=%b c=%b expected v=1 c=100", v, c);
    end
    read_px(8'd10, 7'd10, v, c);
    vectors++;
    if ({v, c} !== 4'b1_011) begin
      miscompares++; $display("FAIL rbw_new: got v=%b c=%b expected v=1 c=011", v, c);
    end
    vectors++;
    if (bus.plot_count !== 15'd1) begin
      miscompares++; $display("FAIL rbw_plot_count: got %0d expected 1", bus.plot_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.rd_req = 1'b1;
    bus.rd_x = 8'd0; bus.rd_y = 7'd0;
    @(negedge clk);
    bus.rd_x = 8'd10; bus.rd_y = 7'd10;
    vectors++;
    if ({bus.rd_valid, bus.rd_colour} !== 4'b1_100) begin
      miscompares++;
      $display("FAIL b2b_0: got v=%b c=%b expected v=1 c=100", bus.rd_valid, bus.rd_colour);
    end
    @(negedge clk);
    bus.rd_x = 8'd200; bus.rd_y = 7'd0;
    vectors++;
    if ({bus.rd_valid, bus.rd_colour} !== 4'b1_011) begin
      miscompares++;
      $display("FAIL b2b_1: got v=%b c=%b expected v=1 c=011", bus.rd_valid, bus.rd_colour);
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    vectors++;
    if ({bus.rd_valid, bus.rd_colour} !== 4'b1_000) begin
      miscompares++;
      $display("FAIL b2b_2: got v=%b c=%b expected v=1 c=000", bus.rd_valid, bus.rd_colour);
    end
    @(negedge clk);
    vectors++;
    if (bus.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_end: got %b expected 0", bus.rd_valid);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, bad;
    logic v;
    logic [2:0] c;
    bus.clear_start  = 1'b1;
    bus.clear_colour = 3'b010;
    @(negedge clk);
    bus.clear_start  = 1'b0;
    repeat (499) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL mid_clear_busy: got %b expected 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy);
    end
    read_px(8'd0, 7'd0, v, c);
    vectors++;
    if ({v, c} !== 4'b1_010) begin
      miscompares++; $display("FAIL abort_head: got v=%b c=%b expected v=1 c=010", v, c);
    end
    read_px(8'd159, 7'd119, v, c);
    vectors++;
    if ({v, c} !== 4'b1_100) begin
      miscompares++; $display("FAIL abort_tail: got v=%b c=%b expected v=1 c=100", v, c);
    end
    run_clear(3'b001, 1'b0, n, bad);
    vectors++;
    if (n != 19200) begin
      miscompares++; $display("FAIL reclear_busy_len: got %0d expected 19200", n);
    end
    read_px(8'd80, 7'd60, v, c);
    vectors++;
    if ({v, c} !== 4'b1_001) begin
      miscompares++; $display("FAIL reclear_read: got v=%b c=%b expected v=1 c=001", v, c);
    end
  endtask

  initial begin
    idle_bus();
    @(negedge clk);
    test_reset();
    test_clear_and_plot();
    test_oob();
    test_reset_with_plot();
    test_clear_sweep();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
